// File: rtl/mux_rr_pkg.sv
// rtl/mux_rr_pkg.sv - lane constants and helpers shared by the round-robin gather mux and its demux
package mux_rr_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_t;

  localparam lane_t S0 = 2'b00;
  localparam lane_t S1 = 2'b01;
  localparam lane_t S2 = 2'b10;
  localparam lane_t S3 = 2'b11;

  // Next lane in rotation; 2-bit wrap makes 3 -> 0.
  function automatic lane_t lane_next(input lane_t lane);
    return lane + 2'd1;
  endfunction

endpackage

// File: rtl/mux_rr_arbitro_rr.sv
// rtl/mux_rr_arbitro_rr.sv - combinational round-robin arbiter, scans from ptr upward
module arbitro_rr
  import mux_rr_pkg::*;
(
  input  logic [NUM_LANES-1:0] pedido,
  input  lane_t                ptr,
  output logic [NUM_LANES-1:0] grant,
  output lane_t                idx,
  output logic                 hay
);

  lane_t cand;

  always_comb begin
    grant = '0;
    idx   = ptr;
    hay   = 1'b0;
    cand  = ptr;
    for (int k = 0; k < NUM_LANES; k++) begin
      cand = ptr + lane_t'(k);
      if (!hay && pedido[cand]) begin
        hay         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr.sv
// rtl/mux_rr.sv - 4-to-1 round-robin gather of show-ahead FIFO lanes into one lane-tagged stream
module mux_rr
  import mux_rr_pkg::*;
#(
  parameter int DATA_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 enb,
  input  logic [DATA_BITS-1:0] entrada0,
  input  logic [DATA_BITS-1:0] entrada1,
  input  logic [DATA_BITS-1:0] entrada2,
  input  logic [DATA_BITS-1:0] entrada3,
  input  logic                 vacio0,
  input  logic                 vacio1,
  input  logic                 vacio2,
  input  logic                 vacio3,
  input  logic                 pausa,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 pop2,
  output logic                 pop3,
  output logic [DATA_BITS-1:0] salida,
  output logic                 valido,
  output logic [1:0]           selector
);

  logic [NUM_LANES-1:0] vacio;
  logic [NUM_LANES-1:0] pedido;
  logic [NUM_LANES-1:0] grant;
  lane_t                idx;
  lane_t                ptr;
  logic                 hay;
  logic [DATA_BITS-1:0] palabra;

  assign vacio  = {vacio3, vacio2, vacio1, vacio0};
  assign pedido = ~vacio & {NUM_LANES{enb & ~pausa}};

  arbitro_rr u_arbitro (
    .pedido (pedido),
    .ptr    (ptr),
    .grant  (grant),
    .idx    (idx),
    .hay    (hay)
  );

  // Pops are forced low during reset so no FIFO head is lost while the register is cleared.
  assign {pop3, pop2, pop1, pop0} = grant & {NUM_LANES{reset_L}};

  always_comb begin
    palabra = entrada0;
    case (idx)
      S0:      palabra = entrada0;
      S1:      palabra = entrada1;
      S2:      palabra = entrada2;
      default: palabra = entrada3;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      salida   <= '0;
      valido   <= 1'b0;
      selector <= S0;
      ptr      <= S0;
    end else if (hay) begin
      salida   <= palabra;
      selector <= idx;
      valido   <= 1'b1;
      ptr      <= lane_next(idx);
    end else begin
      valido   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_rr.sv
// tb/tb_mux_rr.sv - table-driven self-checking bench for mux_rr
module tb_mux_rr;

  typedef struct {
    logic        enb;
    logic        pausa;
    logic [3:0]  vacio;
    logic [15:0] datos;
    logic [3:0]  pop;
    logic        valido;
    logic [1:0]  sel;
    logic [3:0]  sal;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_L = 1'b0;
  logic        enb = 1'b0;
  logic        pausa = 1'b0;
  logic [3:0]  vacio = 4'b1111;
  logic [15:0] datos = 16'h0000;
  logic        pop0, pop1, pop2, pop3;
  logic [3:0]  salida;
  logic        valido;
  logic [1:0]  selector;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t tabla[$];

  always #5 clk = ~clk;

  mux_rr #(.DATA_BITS(4)) dut (
    .clk      (clk),
    .reset_L  (reset_L),
    .enb      (enb),
    .entrada0 (datos[3:0]),
    .entrada1 (datos[7:4]),
    .entrada2 (datos[11:8]),
    .entrada3 (datos[15:12]),
    .vacio0   (vacio[0]),
    .vacio1   (vacio[1]),
    .vacio2   (vacio[2]),
    .vacio3   (vacio[3]),
    .pausa    (pausa),
    .pop0     (pop0),
    .pop1     (pop1),
    .pop2     (pop2),
    .pop3     (pop3),
    .salida   (salida),
    .valido   (valido),
    .selector (selector)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic e, input logic p, input logic [3:0] v, input logic [15:0] d,
                     input logic [3:0] ep, input logic ev, input logic [1:0] es, input logic [3:0] ed);
    vec_t t;
    t.enb = e; t.pausa = p; t.vacio = v; t.datos = d;
    t.pop = ep; t.valido = ev; t.sel = es; t.sal = ed;
    tabla.push_back(t);
  endtask

  initial begin
    // full rotation from ptr=0
    add(1'b1, 1'b0, 4'b0000, 16'hDCBA, 4'b0001, 1'b1, 2'd0, 4'hA);
    add(1'b1, 1'b0, 4'b0000, 16'hDCBA, 4'b0010, 1'b1, 2'd1, 4'hB);
    add(1'b1, 1'b0, 4'b0000, 16'hDCBA, 4'b0100, 1'b1, 2'd2, 4'hC);
    add(1'b1, 1'b0, 4'b0000, 16'hDCBA, 4'b1000, 1'b1, 2'd3, 4'hD);
    // pausa for 4 cycles, then resume at lane 0
    add(1'b1, 1'b1, 4'b0000, 16'hDCBA, 4'b0000, 1'b0, 2'd3, 4'hD);
    add(1'b1, 1'b1, 4'b0000, 16'hDCBA, 4'b0000, 1'b0, 2'd3, 4'hD);
    add(1'b1, 1'b1, 4'b0000, 16'hDCBA, 4'b0000, 1'b0, 2'd3, 4'hD);
    add(1'b1, 1'b1, 4'b0000, 16'hDCBA, 4'b0000, 1'b0, 2'd3, 4'hD);
    add(1'b1, 1'b0, 4'b0000, 16'hDCBA, 4'b0001, 1'b1, 2'd0, 4'hA);
    // enb low: no pops, ptr holds at 1
    add(1'b0, 1'b0, 4'b0000, 16'hDCBA, 4'b0000, 1'b0, 2'd0, 4'hA);
    add(1'b0, 1'b0, 4'b0000, 16'hDCBA, 4'b0000, 1'b0, 2'd0, 4'hA);
    add(1'b1, 1'b0, 4'b0000, 16'hDCBA, 4'b0010, 1'b1, 2'd1, 4'hB);
    // single active lane 2, words 1,2,3 back to back
    add(1'b1, 1'b0, 4'b1011, 16'h0100, 4'b0100, 1'b1, 2'd2, 4'h1);
    add(1'b1, 1'b0, 4'b1011, 16'h0200, 4'b0100, 1'b1, 2'd2, 4'h2);
    add(1'b1, 1'b0, 4'b1011, 16'h0300, 4'b0100, 1'b1, 2'd2, 4'h3);
    add(1'b1, 1'b0, 4'b1111, 16'h0300, 4'b0000, 1'b0, 2'd2, 4'h3);
    // ptr=3, lanes 3 and 0 empty: 1, 2, 1
    add(1'b1, 1'b0, 4'b1001, 16'h0650, 4'b0010, 1'b1, 2'd1, 4'h5);
    add(1'b1, 1'b0, 4'b1001, 16'h0650, 4'b0100, 1'b1, 2'd2, 4'h6);
    add(1'b1, 1'b0, 4'b1001, 16'h0650, 4'b0010, 1'b1, 2'd1, 4'h5);
    // pausa rising together with lanes filling: pausa wins
    add(1'b1, 1'b1, 4'b0000, 16'hDCBA, 4'b0000, 1'b0, 2'd1, 4'h5);
    add(1'b1, 1'b0, 4'b0000, 16'hDCBA, 4'b0100, 1'b1, 2'd2, 4'hC);

    // reset state
    #2;
    check("rst_pops", {28'd0, pop3, pop2, pop1, pop0}, 32'h0);
    @(posedge clk); #1;
    check("rst_salida", {28'd0, salida}, 32'h0);
    check("rst_valido", {31'd0, valido}, 32'h0);
    check("rst_selector", {30'd0, selector}, 32'h0);
    reset_L = 1'b1;

    foreach (tabla[i]) begin
      enb   = tabla[i].enb;
      pausa = tabla[i].pausa;
      vacio = tabla[i].vacio;
      datos = tabla[i].datos;
      #1;
      check($sformatf("v%0d_pop", i), {28'd0, pop3, pop2, pop1, pop0}, {28'd0, tabla[i].pop});
      @(posedge clk); #1;
      check($sformatf("v%0d_valido", i), {31'd0, valido}, {31'd0, tabla[i].valido});
      check($sformatf("v%0d_selector", i), {30'd0, selector}, {30'd0, tabla[i].sel});
      check($sformatf("v%0d_salida", i), {28'd0, salida}, {28'd0, tabla[i].sal});
    end

    // mid-stream reset: ptr=3 so lane 3 is granted, then async clear
    enb = 1'b1; pausa = 1'b0; vacio = 4'b0000; datos = 16'hDCBA;
    @(posedge clk); #1;
    check("mid_valido", {31'd0, valido}, 32'h1);
    check("mid_selector", {30'd0, selector}, 32'h3);
    #2;
    reset_L = 1'b0;
    #1;
    check("arst_salida", {28'd0, salida}, 32'h0);
    check("arst_valido", {31'd0, valido}, 32'h0);
    check("arst_selector", {30'd0, selector}, 32'h0);
    check("arst_pops", {28'd0, pop3, pop2, pop1, pop0}, 32'h0);
    @(posedge clk); #1;
    reset_L = 1'b1;
    #1;
    check("post_rst_pop", {28'd0, pop3, pop2, pop1, pop0}, 32'h1);
    @(posedge clk); #1;
    check("post_rst_selector", {30'd0, selector}, 32'h0);
    check("post_rst_salida", {28'd0, salida}, 32'hA);
    check("post_rst_valido", {31'd0, valido}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
